// File: rtl/seg7_scan_driver_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared types and constants for the multiplexed 7-segment scan driver:
//   - state_t       : scan FSM states (IDLE, BLANK, SHOW)
//   - HEX_SEG_TABLE : hex nibble -> active-high {g,f,e,d,c,b,a} segment codes
//   - SEG_OFF       : active-high "all segments off" code
// ---------------------------------------------------------------------------
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    localparam logic [6:0] SEG_OFF = 7'h00;

    // Entry [n] is the glyph for hex digit n (listed F down to 0 so that
    // the packed index matches the nibble value).
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg7_scan_driver_if.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver_if
// Bundles the display request (enable, value, dp_in) and the pin-side scan
// outputs (seg, dp, an, digit_idx, frame_tick) of seg7_scan_driver.
//   master : core-logic side, drives the request, observes the scan outputs
//   slave  : the scan driver itself
// ---------------------------------------------------------------------------
interface seg7_scan_driver_if;
    logic        enable;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic [1:0]  digit_idx;
    logic        frame_tick;

    modport master (
        output enable, value, dp_in,
        input  seg, dp, an, digit_idx, frame_tick
    );

    modport slave (
        input  enable, value, dp_in,
        output seg, dp, an, digit_idx, frame_tick
    );
endinterface

// File: rtl/seg7_scan_driver_hex_to_seg7.sv
// ---------------------------------------------------------------------------
// hex_to_seg7
// Combinational hex nibble to 7-segment decoder, active-high {g,f,e,d,c,b,a}.
//   i_nibble : 4-bit hex value
//   o_seg    : segment pattern, 1 = segment lit
// ---------------------------------------------------------------------------
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = HEX_SEG_TABLE[i_nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver
// Latches a 16-bit value (four hex nibbles) once per frame and time-multiplexes
// it onto a 4-digit 7-segment display. Each digit slot lasts 2**SCAN_DIV_W
// clocks; the first BLANK_CYCLES of each slot keep anodes and segments dark to
// stop ghosting between digits.
// Ports:
//   clk, rst_n     : clock (posedge) and asynchronous active-low reset
//   bus (slave)    : enable, value, dp_in in; seg, dp, an, digit_idx,
//                    frame_tick out (all outputs registered)
// Optional build macro:
//   SEG7_LEADING_ZERO_BLANK_EN : keep leading-zero digits 3..1 dark
// ---------------------------------------------------------------------------
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV_W   = 17,
    parameter int BLANK_CYCLES = 64,
    parameter bit SEG_ACT_LOW  = 1'b1,
    parameter bit AN_ACT_LOW   = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    seg7_scan_driver_if.slave bus
);

    localparam logic [SCAN_DIV_W-1:0] CNT_MAX   = '1;
    localparam logic [SCAN_DIV_W-1:0] BLANK_LIM = SCAN_DIV_W'(BLANK_CYCLES);
    localparam logic [6:0] SEG_PIN_OFF = SEG_ACT_LOW ? ~SEG_OFF : SEG_OFF;
    localparam logic       DP_PIN_OFF  = SEG_ACT_LOW ? 1'b1 : 1'b0;
    localparam logic [3:0] AN_PIN_OFF  = AN_ACT_LOW ? 4'hF : 4'h0;

    state_t                r_state,   w_state_nx;
    logic [SCAN_DIV_W-1:0] r_cnt,     w_cnt_nx;
    logic [1:0]            r_digit,   w_digit_nx;
    logic [15:0]           r_val,     w_val_nx;
    logic [3:0]            r_dpl,     w_dpl_nx;
    logic                  w_tick_nx;

    logic [6:0] r_seg;
    logic       r_dp;
    logic [3:0] r_an;
    logic       r_tick;

    logic [3:0] w_nib_nx;
    logic [6:0] w_seg_hi;
    logic       w_visible;
    logic       w_lit;
    logic [6:0] w_seg_pin;
    logic       w_dp_pin;
    logic [3:0] w_an_pin;

    // Next-state logic. Outputs are decoded from these next values so the
    // registered pins line up with the registered state on the same cycle.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_digit_nx = r_digit;
        w_val_nx   = r_val;
        w_dpl_nx   = r_dpl;
        w_tick_nx  = 1'b0;

        if (!bus.enable) begin
            w_state_nx = IDLE;
            w_cnt_nx   = '0;
            w_digit_nx = 2'd0;
        end else if (r_state == IDLE) begin
            // Fresh start: a new frame begins with a fresh latch.
            w_cnt_nx   = '0;
            w_digit_nx = 2'd0;
            w_val_nx   = bus.value;
            w_dpl_nx   = bus.dp_in;
            w_tick_nx  = 1'b1;
            w_state_nx = (w_cnt_nx < BLANK_LIM) ? BLANK : SHOW;
        end else begin
            if (r_cnt == CNT_MAX) begin
                w_cnt_nx   = '0;
                w_digit_nx = r_digit + 2'd1;
                // Only re-latch at frame start so a frame is always coherent.
                if (r_digit == 2'd3) begin
                    w_val_nx  = bus.value;
                    w_dpl_nx  = bus.dp_in;
                    w_tick_nx = 1'b1;
                end
            end else begin
                w_cnt_nx = r_cnt + 1'b1;
            end
            w_state_nx = (w_cnt_nx < BLANK_LIM) ? BLANK : SHOW;
        end
    end

    assign w_nib_nx = w_val_nx[{w_digit_nx, 2'b00} +: 4];

    hex_to_seg7 u_hex_to_seg7 (
        .i_nibble (w_nib_nx),
        .o_seg    (w_seg_hi)
    );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // Digit k is a leading zero when nibbles k..3 are all zero; digit 0
    // always shows so a zero value still displays '0'.
    always_comb begin
        case (w_digit_nx)
            2'd3:    w_visible = |w_val_nx[15:12];
            2'd2:    w_visible = |w_val_nx[15:8];
            2'd1:    w_visible = |w_val_nx[15:4];
            default: w_visible = 1'b1;
        endcase
    end
`else
    assign w_visible = 1'b1;
`endif

    assign w_lit     = (w_state_nx == SHOW) && w_visible;
    assign w_seg_pin = w_lit ? (SEG_ACT_LOW ? ~w_seg_hi : w_seg_hi) : SEG_PIN_OFF;
    assign w_dp_pin  = w_lit ? (w_dpl_nx[w_digit_nx] ^ SEG_ACT_LOW) : DP_PIN_OFF;
    assign w_an_pin  = w_lit ? (AN_ACT_LOW ? ~(4'b0001 << w_digit_nx)
                                           : (4'b0001 << w_digit_nx))
                             : AN_PIN_OFF;

    // State and output registers; reset darkens the display immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_digit <= 2'd0;
            r_val   <= 16'h0000;
            r_dpl   <= 4'h0;
            r_seg   <= SEG_PIN_OFF;
            r_dp    <= DP_PIN_OFF;
            r_an    <= AN_PIN_OFF;
            r_tick  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_digit <= w_digit_nx;
            r_val   <= w_val_nx;
            r_dpl   <= w_dpl_nx;
            r_seg   <= w_seg_pin;
            r_dp    <= w_dp_pin;
            r_an    <= w_an_pin;
            r_tick  <= w_tick_nx;
        end
    end

    assign bus.seg        = r_seg;
    assign bus.dp         = r_dp;
    assign bus.an         = r_an;
    assign bus.digit_idx  = r_digit;
    assign bus.frame_tick = r_tick;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_driver
// Directed bench for seg7_scan_driver with a 16-clock slot (2 blank + 14 show)
// and a 64-clock frame, active-low segments and anodes.
// Observed word per cycle: {an[3:0], seg[6:0], dp, digit_idx[1:0], frame_tick}.
// ---------------------------------------------------------------------------
module tb_seg7_scan_driver;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    seg7_scan_driver_if bif();

    seg7_scan_driver #(
        .SCAN_DIV_W   (4),
        .BLANK_CYCLES (2),
        .SEG_ACT_LOW  (1'b1),
        .AN_ACT_LOW   (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] observed();
        return {bif.an, bif.seg, bif.dp, bif.digit_idx, bif.frame_tick};
    endfunction

    // Expected word for slot d, cycle c of a slot (dark during blank).
    function automatic logic [14:0] expect_word(int d, int c, logic [6:0] seg_n,
                                                logic dp_n, logic lit);
        logic [3:0] an_n;
        logic [1:0] di;
        di   = 2'(d);
        an_n = ~(4'b0001 << di);
        if (c < 2 || !lit)
            return {4'hF, 7'h7F, 1'b1, di, (d == 0 && c == 0)};
        return {an_n, seg_n, dp_n, di, 1'b0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bring the driver back through IDLE and start a fresh frame.
    task automatic restart(input logic [15:0] v, input logic [3:0] d);
        bif.enable = 1'b0;
        step();
        bif.value  = v;
        bif.dp_in  = d;
        bif.enable = 1'b1;
        step();
    endtask

    task automatic test_reset();
        logic [14:0] obs;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        obs = observed();
        checks++;
        if (obs !== {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_initial: got %h expected %h", obs, {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0});
        end
        @(negedge clk) rst_n = 1'b1;
        restart(16'h1234, 4'h0);
        repeat (20) step();
        obs = observed();
        checks++;
        if (obs !== {4'b1101, 7'h30, 1'b1, 2'd1, 1'b0}) begin
            errors++;
            $display("FAIL reset_prerun: got %h expected %h", obs, {4'b1101, 7'h30, 1'b1, 2'd1, 1'b0});
        end
        // Assert reset while clk is high: no clock edge between assert and check.
        #1 rst_n = 1'b0;
        #1;
        obs = observed();
        checks++;
        if (obs !== {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_async: got %h expected %h", obs, {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0});
        end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_scan();
        logic [6:0]  s1234 [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
        logic [14:0] obs, exp;
        restart(16'h1234, 4'h0);
        for (int p = 0; p < 128; p++) begin
            exp = expect_word((p / 16) % 4, p % 16, s1234[(p / 16) % 4], 1'b1, 1'b1);
            obs = observed();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL scan_1234 pos %0d: got %h expected %h", p, obs, exp);
            end
            step();
        end
    endtask

    task automatic test_frame_coherence();
        logic [6:0]  s1234 [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
        logic [6:0]  sabcd [4] = '{7'h21, 7'h46, 7'h03, 7'h08};
        logic [14:0] obs, exp;
        restart(16'h1234, 4'h0);
        for (int p = 0; p < 128; p++) begin
            exp = expect_word((p / 16) % 4, p % 16,
                              (p < 64) ? s1234[(p / 16) % 4] : sabcd[(p / 16) % 4],
                              1'b1, 1'b1);
            obs = observed();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL coherence pos %0d: got %h expected %h", p, obs, exp);
            end
            step();
            if (p == 19) bif.value = 16'hABCD;
        end
    endtask

    task automatic test_dp();
        logic [6:0]  s1234 [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
        logic [14:0] obs, exp;
        restart(16'h1234, 4'b0100);
        for (int p = 0; p < 64; p++) begin
            exp = expect_word(p / 16, p % 16, s1234[p / 16], (p / 16 == 2) ? 1'b0 : 1'b1, 1'b1);
            obs = observed();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL dp pos %0d: got %h expected %h", p, obs, exp);
            end
            step();
        end
    endtask

    task automatic test_enable_drop();
        logic [14:0] obs;
        restart(16'h1234, 4'h0);
        repeat (37) step();
        obs = observed();
        checks++;
        if (obs !== {4'b1011, 7'h24, 1'b1, 2'd2, 1'b0}) begin
            errors++;
            $display("FAIL endrop_show2: got %h expected %h", obs, {4'b1011, 7'h24, 1'b1, 2'd2, 1'b0});
        end
        bif.enable = 1'b0;
        step();
        obs = observed();
        checks++;
        if (obs !== {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL endrop_idle: got %h expected %h", obs, {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0});
        end
        repeat (3) step();
        obs = observed();
        checks++;
        if (obs !== {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL endrop_hold: got %h expected %h", obs, {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0});
        end
        bif.enable = 1'b1;
        step();
        obs = observed();
        checks++;
        if (obs !== {4'hF, 7'h7F, 1'b1, 2'd0, 1'b1}) begin
            errors++;
            $display("FAIL endrop_restart: got %h expected %h", obs, {4'hF, 7'h7F, 1'b1, 2'd0, 1'b1});
        end
        repeat (2) step();
        obs = observed();
        checks++;
        if (obs !== {4'b1110, 7'h19, 1'b1, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL endrop_show0: got %h expected %h", obs, {4'b1110, 7'h19, 1'b1, 2'd0, 1'b0});
        end
        // Drop enable on the last cycle of a frame, re-enable with a new value.
        restart(16'h1234, 4'h0);
        repeat (63) step();
        bif.enable = 1'b0;
        step();
        obs = observed();
        checks++;
        if (obs !== {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL wrap_idle: got %h expected %h", obs, {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0});
        end
        bif.value  = 16'hABCD;
        bif.enable = 1'b1;
        step();
        obs = observed();
        checks++;
        if (obs !== {4'hF, 7'h7F, 1'b1, 2'd0, 1'b1}) begin
            errors++;
            $display("FAIL wrap_restart: got %h expected %h", obs, {4'hF, 7'h7F, 1'b1, 2'd0, 1'b1});
        end
        repeat (2) step();
        obs = observed();
        checks++;
        if (obs !== {4'b1110, 7'h21, 1'b1, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL wrap_fresh_latch: got %h expected %h", obs, {4'b1110, 7'h21, 1'b1, 2'd0, 1'b0});
        end
    endtask

    task automatic test_leading_zero();
        logic [6:0]  s0042 [4] = '{7'h24, 7'h19, 7'h40, 7'h40};
        logic [14:0] obs, exp;
        logic        lit;
        restart(16'h0042, 4'h0);
        for (int p = 0; p < 64; p++) begin
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            lit = (p / 16) <= 1;
`else
            lit = 1'b1;
`endif
            exp = expect_word(p / 16, p % 16, s0042[p / 16], 1'b1, lit);
            obs = observed();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL lzb_0042 pos %0d: got %h expected %h", p, obs, exp);
            end
            step();
        end
        restart(16'h0000, 4'h0);
        for (int p = 0; p < 64; p++) begin
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            lit = (p / 16) == 0;
`else
            lit = 1'b1;
`endif
            exp = expect_word(p / 16, p % 16, 7'h40, 1'b1, lit);
            obs = observed();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL lzb_0000 pos %0d: got %h expected %h", p, obs, exp);
            end
            step();
        end
    endtask

    initial begin
        bif.enable = 1'b0;
        bif.value  = 16'h0000;
        bif.dp_in  = 4'h0;
        test_reset();
        test_scan();
        test_frame_coherence();
        test_dp();
        test_enable_drop();
        test_leading_zero();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
